// File: rtl/ray_march_engine_pkg.sv
// Shared types and fixed-point helpers for the ray marching engine.
//   fp     : signed Q16.16 fixed point
//   vec3   : packed {x, y, z} of fp
//   RayEngineState : engine FSM states
// All fp arithmetic saturates to the representable range instead of wrapping.
package ray_march_engine_pkg;

  localparam int FP_W    = 32;
  localparam int FP_FRAC = 16;

  typedef logic signed [FP_W-1:0]   fp;
  typedef logic signed [2*FP_W-1:0] fpw;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  typedef enum logic [1:0] {
    RE_Ready,
    RE_Issue,
    RE_Wait,
    RE_Done
  } RayEngineState;

  localparam fp  FP_MAX  = {1'b0, {(FP_W-1){1'b1}}};
  localparam fp  FP_MIN  = {1'b1, {(FP_W-1){1'b0}}};
  localparam fpw FPW_MAX = fpw'(FP_MAX);
  localparam fpw FPW_MIN = fpw'(FP_MIN);

  // 0.01 -> round(0.01 * 65536) = 655
  localparam fp HIT_EPS_DEF  = fp'(655);
  // 16.0
  localparam fp MAX_DIST_DEF = fp'(16 * 65536);

  function automatic fp fp_sat(input fpw v);
    if (v > FPW_MAX) return FP_MAX;
    if (v < FPW_MIN) return FP_MIN;
    return v[FP_W-1:0];
  endfunction

  function automatic fp fp_add(input fp a, input fp b);
    return fp_sat(fpw'(a) + fpw'(b));
  endfunction

  // Product is rescaled with an arithmetic shift, i.e. rounds toward -inf.
  function automatic fp fp_mul(input fp a, input fp b);
    fpw p;
    p = fpw'(a) * fpw'(b);
    return fp_sat(p >>> FP_FRAC);
  endfunction

  function automatic vec3 vec3_scaled(input vec3 v, input fp s);
    vec3 r;
    r.x = fp_mul(v.x, s);
    r.y = fp_mul(v.y, s);
    r.z = fp_mul(v.z, s);
    return r;
  endfunction

  function automatic vec3 vec3_add(input vec3 a, input vec3 b);
    vec3 r;
    r.x = fp_add(a.x, b.x);
    r.y = fp_add(a.y, b.y);
    r.z = fp_add(a.z, b.z);
    return r;
  endfunction

endpackage

// File: rtl/ray_march_engine_if.sv
// Handshake bundle around one ray marching engine.
//   ray in   : valid_in/ready_out + origin, direction, pixel tags
//   sdf      : sdf_req_out/sdf_point_out out, sdf_valid_in/sdf_dist_in back
//   result   : valid_out/ready_in + tags, colour, hit, depth, distance
// Modport slave is the engine side, master is the surrounding system.
interface ray_march_engine_if
  import ray_march_engine_pkg::*;
#(
  parameter int H_BITS     = 11,
  parameter int V_BITS     = 10,
  parameter int COLOR_BITS = 4,
  parameter int DEPTH_W    = 7
) ();

  logic                  valid_in;
  logic                  ready_out;
  vec3                   ray_origin_in;
  vec3                   ray_direction_in;
  logic [H_BITS-1:0]     hcount_in;
  logic [V_BITS-1:0]     vcount_in;

  logic                  sdf_req_out;
  vec3                   sdf_point_out;
  logic                  sdf_valid_in;
  fp                     sdf_dist_in;

  logic                  valid_out;
  logic                  ready_in;
  logic [H_BITS-1:0]     hcount_out;
  logic [V_BITS-1:0]     vcount_out;
  logic [COLOR_BITS-1:0] color_out;
  logic                  hit_out;
  logic [DEPTH_W-1:0]    depth_out;
  fp                     dist_out;

  modport slave (
    input  valid_in, ray_origin_in, ray_direction_in, hcount_in, vcount_in,
    input  sdf_valid_in, sdf_dist_in, ready_in,
    output ready_out, sdf_req_out, sdf_point_out,
    output valid_out, hcount_out, vcount_out, color_out, hit_out, depth_out, dist_out
  );

  modport master (
    output valid_in, ray_origin_in, ray_direction_in, hcount_in, vcount_in,
    output sdf_valid_in, sdf_dist_in, ready_in,
    input  ready_out, sdf_req_out, sdf_point_out,
    input  valid_out, hcount_out, vcount_out, color_out, hit_out, depth_out, dist_out
  );

endinterface

// File: rtl/ray_march_engine_march_step.sv
// One sphere-tracing advance: pos_o = pos_i + dir_i * step_i (saturating).
//   pos_i  : current ray position
//   dir_i  : ray direction
//   step_i : distance to advance
//   pos_o  : advanced position
module march_step
  import ray_march_engine_pkg::*;
(
  input  vec3 pos_i,
  input  vec3 dir_i,
  input  fp   step_i,
  output vec3 pos_o
);

  assign pos_o = vec3_add(pos_i, vec3_scaled(dir_i, step_i));

endmodule

// File: rtl/ray_march_engine.sv
// Single-ray sphere tracer driving an external multi-cycle SDF evaluator.
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (slave)    : ray input handshake, SDF request/response, result
//                    handshake (see ray_march_engine_if)
// A ray is accepted in RE_Ready, each query is issued for one cycle in
// RE_Issue, the engine parks in RE_Wait for the result, and the finished
// ray is held in RE_Done until the consumer takes it.
module ray_march_engine
  import ray_march_engine_pkg::*;
#(
  parameter int H_BITS        = 11,
  parameter int V_BITS        = 10,
  parameter int MAX_RAY_DEPTH = 64,
  parameter int COLOR_BITS    = 4,
  parameter fp  HIT_EPS       = HIT_EPS_DEF,
  parameter fp  MAX_DIST      = MAX_DIST_DEF,
  localparam int DEPTH_W      = $clog2(MAX_RAY_DEPTH + 1)
) (
  input logic clk_in,
  input logic rst_in,
  ray_march_engine_if.slave bus
);

  // Internal counter only needs 0..MAX_RAY_DEPTH-1; the depth-limit case
  // reports MAX_RAY_DEPTH directly.
  localparam int CNT_W = $clog2(MAX_RAY_DEPTH);
  localparam int SHIFT = CNT_W - COLOR_BITS;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(MAX_RAY_DEPTH - 1);
  localparam logic [COLOR_BITS-1:0] COLOR_MAX = '1;

  RayEngineState         state_q;
  vec3                   pos_q, dir_q, pos_d;
  fp                     t_q, t_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [H_BITS-1:0]     hcount_q;
  logic [V_BITS-1:0]     vcount_q;
  logic                  sdf_req_q, valid_q, hit_q;
  logic [COLOR_BITS-1:0] color_q, shade;
  logic [DEPTH_W-1:0]    depth_q;
  fp                     dist_q;
  logic                  is_hit, is_far, is_lim;
  logic [CNT_W-1:0]      cnt_sh;

  march_step u_step (
    .pos_i  (pos_q),
    .dir_i  (dir_q),
    .step_i (bus.sdf_dist_in),
    .pos_o  (pos_d)
  );

  // Termination tests on the incoming distance; only meaningful on a
  // result cycle in RE_Wait.
  always_comb begin
    t_d    = fp_add(t_q, bus.sdf_dist_in);
    is_hit = (bus.sdf_dist_in < HIT_EPS);
    is_far = (t_d > MAX_DIST);
    is_lim = (cnt_q == CNT_LAST);
    cnt_sh = cnt_q >> SHIFT;
    shade  = COLOR_MAX - cnt_sh[COLOR_BITS-1:0];
    // A hit must stay distinguishable from a miss (colour 0).
    if (shade == '0) shade = COLOR_BITS'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= RE_Ready;
      pos_q     <= '0;
      dir_q     <= '0;
      t_q       <= '0;
      cnt_q     <= '0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      sdf_req_q <= 1'b0;
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      color_q   <= '0;
      depth_q   <= '0;
      dist_q    <= '0;
    end else begin
      sdf_req_q <= 1'b0;
      case (state_q)
        RE_Ready: begin
          if (bus.valid_in) begin
            pos_q     <= bus.ray_origin_in;
            dir_q     <= bus.ray_direction_in;
            hcount_q  <= bus.hcount_in;
            vcount_q  <= bus.vcount_in;
            t_q       <= '0;
            cnt_q     <= '0;
            sdf_req_q <= 1'b1;
            state_q   <= RE_Issue;
          end
        end
        RE_Issue: state_q <= RE_Wait;
        RE_Wait: begin
          if (bus.sdf_valid_in) begin
            if (is_hit || is_far || is_lim) begin
              valid_q <= 1'b1;
              hit_q   <= is_hit;
              color_q <= is_hit ? shade : '0;
              depth_q <= (!is_hit && !is_far) ? DEPTH_W'(MAX_RAY_DEPTH)
                                              : DEPTH_W'(cnt_q);
              dist_q  <= t_q;
              state_q <= RE_Done;
            end else begin
              pos_q     <= pos_d;
              t_q       <= t_d;
              cnt_q     <= cnt_q + 1'b1;
              sdf_req_q <= 1'b1;
              state_q   <= RE_Issue;
            end
          end
        end
        RE_Done: begin
          if (valid_q && bus.ready_in) begin
            valid_q <= 1'b0;
            state_q <= RE_Ready;
          end
        end
        default: state_q <= RE_Ready;
      endcase
    end
  end

  assign bus.ready_out     = (state_q == RE_Ready);
  assign bus.sdf_req_out   = sdf_req_q;
  assign bus.sdf_point_out = pos_q;
  assign bus.valid_out     = valid_q;
  assign bus.hit_out       = hit_q;
  assign bus.color_out     = color_q;
  assign bus.depth_out     = depth_q;
  assign bus.dist_out      = dist_q;
  assign bus.hcount_out    = hcount_q;
  assign bus.vcount_out    = vcount_q;

endmodule

// File: tb/tb_ray_march_engine.sv
// Self-checking bench for ray_march_engine: an SDF responder with
// configurable latency, a reference sphere tracer in plain integer math,
// directed rays and randomized rays.
module tb_ray_march_engine;
  import ray_march_engine_pkg::*;

  localparam longint ONE  = 65536;
  localparam longint EPS  = 655;
  localparam longint MAXD = 16 * 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ray_march_engine_if #(.H_BITS(11), .V_BITS(10), .COLOR_BITS(4), .DEPTH_W(7)) bus ();

  ray_march_engine #(.H_BITS(11), .V_BITS(10), .MAX_RAY_DEPTH(64), .COLOR_BITS(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // current ray and its distance script
  longint r_org[3], r_dir[3];
  longint dq[$];
  int     r_hc, r_vc;

  // reference results
  logic [95:0] exp_pts[$];
  int     m_hit, m_depth, m_color;
  longint m_dist;

  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint dist_at(input int n);
    return (n < dq.size()) ? dq[n] : dq[dq.size()-1];
  endfunction

  function automatic logic [95:0] pack3(input longint x, input longint y, input longint z);
    return {x[31:0], y[31:0], z[31:0]};
  endfunction

  function automatic logic [95:0] pk(input bit v, input bit h, input int c, input int dp,
                                     input longint ds, input int hc, input int vc,
                                     input bit r, input bit q);
    return {28'd0, v, h, c[3:0], dp[6:0], ds[31:0], hc[10:0], vc[9:0], r, q};
  endfunction

  // Sphere tracing as described: query, then hit / far plane / depth limit,
  // otherwise step along the ray by d.
  task automatic predict();
    longint p[3];
    longint t, d;
    int n;
    p = r_org; t = 0; n = 0;
    exp_pts.delete();
    forever begin
      exp_pts.push_back(pack3(p[0], p[1], p[2]));
      d = dist_at(n);
      if (d < EPS) begin
        m_hit = 1; m_depth = n; m_dist = t;
        m_color = (15 - n / 4 < 1) ? 1 : 15 - n / 4;
        return;
      end
      if (sat(t + d) > MAXD) begin
        m_hit = 0; m_depth = n; m_dist = t; m_color = 0;
        return;
      end
      if (n + 1 == 64) begin
        m_hit = 0; m_depth = 64; m_dist = t; m_color = 0;
        return;
      end
      for (int k = 0; k < 3; k++) p[k] = sat(p[k] + sat((r_dir[k] * d) >>> 16));
      t = sat(t + d);
      n++;
    end
  endtask

  task automatic start_ray(input string tag);
    int w;
    w = 0;
    while (!bus.ready_out && w < 100) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, bus.ready_out, 1);
    r_hc = $urandom_range(0, 2047);
    r_vc = $urandom_range(0, 1023);
    bus.valid_in         = 1'b1;
    bus.ray_origin_in    = pack3(r_org[0], r_org[1], r_org[2]);
    bus.ray_direction_in = pack3(r_dir[0], r_dir[1], r_dir[2]);
    bus.hcount_in        = r_hc[10:0];
    bus.vcount_in        = r_vc[9:0];
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  // Runs one ray to completion with SDF latency L, optionally checks the
  // accept-to-valid latency, holds the result for 'hold' cycles, releases it.
  task automatic run_ray(input string tag, input int L, input int hold, input int lat_exp);
    int cyc, nreq, pend;
    bit done;
    predict();
    start_ray(tag);
    cyc = 1; nreq = 0; pend = 0; done = 0;
    while (cyc < 5000) begin
      bus.sdf_valid_in = 1'b0;
      bus.sdf_dist_in  = fp'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.sdf_valid_in = 1'b1;
          bus.sdf_dist_in  = fp'(dist_at(nreq - 1));
        end
      end
      if (bus.sdf_req_out) begin
        if (nreq < exp_pts.size()) chk({tag, "_point"}, bus.sdf_point_out, exp_pts[nreq]);
        else chk({tag, "_extra_query"}, nreq, exp_pts.size() - 1);
        nreq++;
        pend = L;
      end
      if (bus.valid_out) begin done = 1; break; end
      @(negedge clk);
      cyc++;
    end
    bus.sdf_valid_in = 1'b0;
    chk({tag, "_finished"}, done, 1);
    if (lat_exp >= 0) chk({tag, "_latency"}, cyc, lat_exp);
    chk({tag, "_queries"}, nreq, exp_pts.size());
    chk({tag, "_result"},
        pk(bus.valid_out, bus.hit_out, bus.color_out, bus.depth_out, bus.dist_out,
           bus.hcount_out, bus.vcount_out, bus.ready_out, bus.sdf_req_out),
        pk(1, m_hit[0], m_color, m_depth, m_dist, r_hc, r_vc, 0, 0));
    for (int i = 0; i < hold; i++) begin
      bus.valid_in      = 1'b1;
      bus.hcount_in     = 11'($urandom);
      bus.ray_origin_in = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk({tag, "_hold"},
          pk(bus.valid_out, bus.hit_out, bus.color_out, bus.depth_out, bus.dist_out,
             bus.hcount_out, bus.vcount_out, bus.ready_out, bus.sdf_req_out),
          pk(1, m_hit[0], m_color, m_depth, m_dist, r_hc, r_vc, 0, 0));
    end
    // valid_in stays high across the release edge: it must not be taken.
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b1;
    @(negedge clk);
    chk({tag, "_release"}, {bus.ready_out, bus.valid_out, bus.sdf_req_out}, 3'b100);
    bus.ready_in = 1'b0;
    bus.valid_in = 1'b0;
  endtask

  task automatic set_ray(input longint oz, input longint dz);
    r_org[0] = 0; r_org[1] = 0; r_org[2] = oz;
    r_dir[0] = 0; r_dir[1] = 0; r_dir[2] = dz;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, mode;
    bus.valid_in = 1'b0; bus.ready_in = 1'b0; bus.sdf_valid_in = 1'b0;
    bus.sdf_dist_in = '0; bus.hcount_in = '0; bus.vcount_in = '0;
    bus.ray_origin_in = '0; bus.ray_direction_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", pk(bus.valid_out, bus.hit_out, bus.color_out, bus.depth_out, bus.dist_out,
                          bus.hcount_out, bus.vcount_out, bus.ready_out, bus.sdf_req_out),
        pk(0, 0, 0, 0, 0, 0, 0, 1, 0));

    // stray SDF result while idle
    bus.sdf_valid_in = 1'b1; bus.sdf_dist_in = '0;
    @(negedge clk);
    bus.sdf_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("spurious_sdf", {bus.ready_out, bus.valid_out, bus.sdf_req_out}, 3'b100);
      @(negedge clk);
    end

    // first-query hit, latency 3
    set_ray(-5 * ONE, ONE); dq = '{328};
    run_ray("first_hit", 3, 0, 5);
    // three steps then hit at z=-2
    set_ray(-5 * ONE, ONE); dq = '{ONE, ONE, ONE, 0};
    run_ray("four_query", 2, 0, -1);
    // far plane after 32 steps
    set_ray(-5 * ONE, ONE); dq = '{32768};
    run_ray("far_plane", 2, 0, -1);
    // depth limit: 64 queries
    set_ray(-5 * ONE, ONE); dq = '{6554};
    run_ray("depth_limit", 1, 0, -1);
    // result held under backpressure
    set_ray(-5 * ONE, ONE); dq = '{-ONE};
    run_ray("backpressure", 2, 10, -1);

    // reset while waiting for the SDF result
    set_ray(-5 * ONE, ONE);
    start_ray("mid_reset");
    w = 0;
    while (!bus.sdf_req_out && w < 20) begin @(negedge clk); w++; end
    chk("mid_reset_req", bus.sdf_req_out, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.sdf_valid_in = 1'b1; bus.sdf_dist_in = '0;
    @(negedge clk);
    bus.sdf_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_reset_idle", pk(bus.valid_out, bus.hit_out, bus.color_out, bus.depth_out, bus.dist_out,
                               bus.hcount_out, bus.vcount_out, bus.ready_out, bus.sdf_req_out),
          pk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      @(negedge clk);
    end

    // randomized rays: mixed, depth-limit-prone, far-plane-prone scripts
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 3; k++) begin
        r_org[k] = longint'($urandom_range(0, 1048576)) - 524288;
        r_dir[k] = longint'($urandom_range(0, 131072)) - 65536;
      end
      dq.delete();
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 70; i++) begin
        case (mode)
          0:       dq.push_back(longint'($urandom_range(0, 40000)) - 500);
          1:       dq.push_back(longint'($urandom_range(3000, 9000)));
          default: dq.push_back(longint'($urandom_range(20000, 90000)));
        endcase
      end
      run_ray("random", $urandom_range(1, 4), $urandom_range(0, 2), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ray_march_engine.md
Name: ray_march_engine

Overview:
Parametrised successor to the single-ray marching unit. Accepts one ray (origin, direction, pixel coordinates), iterates sphere-tracing steps against an external, multi-cycle SDF evaluator through a request/response handshake, and tracks accumulated distance. Terminates on hit, depth limit or far plane. Emits a depth-shaded colour through a valid/ready output handshake. Several instances sit between the ray generator and the framebuffer writer.

Parameters:
H_BITS, `H_BITS, hcount width
V_BITS, `V_BITS, vcount width
MAX_RAY_DEPTH, 64, max SDF queries per ray; power of two, >= 2**COLOR_BITS
COLOR_BITS, 4, colour output width
HIT_EPS, fp 0.01, hit threshold
MAX_DIST, fp 16.0, far-plane distance on accumulated t

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous, active-high reset
valid_in  in  1  ray offered
ready_out  out  1  engine idle; ray accepted when valid_in && ready_out
ray_origin_in  in  vec3  ray start
ray_direction_in  in  vec3  unit direction
hcount_in  in  H_BITS  pixel x tag
vcount_in  in  V_BITS  pixel y tag
sdf_req_out  out  1  one-cycle SDF query strobe
sdf_point_out  out  vec3  query point; valid while sdf_req_out=1
sdf_valid_in  in  1  SDF result strobe
sdf_dist_in  in  fp  signed distance; sampled only with sdf_valid_in
valid_out  out  1  result available
ready_in  in  1  downstream accepts
hcount_out  out  H_BITS  tag of finished ray
vcount_out  out  V_BITS  tag of finished ray
color_out  out  COLOR_BITS  shade
hit_out  out  1  1 = hit, 0 = miss/far
depth_out  out  $clog2(MAX_RAY_DEPTH+1)  queries completed before termination
dist_out  out  fp  accumulated t

Behaviour:
- States: RE_Ready, RE_Issue, RE_Wait, RE_Done. Reset (any state, mid-ray included) -> RE_Ready; valid_out, sdf_req_out, hit_out = 0; color_out, depth_out, dist_out, hcount_out, vcount_out = 0. Pending SDF result after reset is ignored.
- ready_out = (state == RE_Ready), combinational.
- RE_Ready: on valid_in, latch origin, direction, tags; t = 0; depth = 0; -> RE_Issue.
- RE_Issue: sdf_req_out = 1 for exactly this cycle, sdf_point_out = current position; -> RE_Wait.
- RE_Wait: hold until sdf_valid_in. sdf_valid_in in any other state is ignored. On the result cycle, d = sdf_dist_in, evaluated in this priority:
  1. d < HIT_EPS (signed; negative d counts as hit): hit=1, -> RE_Done.
  2. t + d > MAX_DIST: hit=0, -> RE_Done.
  3. depth+1 == MAX_RAY_DEPTH: hit=0, depth_out = MAX_RAY_DEPTH, -> RE_Done.
  4. Otherwise: pos <= pos + dir*d, t <= t + d, depth <= depth+1, -> RE_Issue.
- depth_out = number of queries before the terminating one. dist_out = t excluding the terminating d.
- Shade on hit: COLOR_MAX - (depth >> ($clog2(MAX_RAY_DEPTH) - COLOR_BITS)), clamped to a minimum of 1. Shade on miss = 0. COLOR_MAX = 2**COLOR_BITS - 1.
- RE_Done: valid_out = 1, all outputs stable. On valid_out && ready_in -> RE_Ready next cycle, with valid_out deasserted. No back-to-back acceptance in that same cycle.
- Minimum latency for a first-query hit with SDF latency L: accept cycle + 1 (Issue) + L + 1 -> valid_out.
- fp arithmetic uses the shared fixed-point helpers and saturates per the package. t addition saturates rather than wraps.

Decomposition:
- Shared types package: fp, vec3, the RayEngineState enum (RE_*), and fp constants for HIT_EPS and MAX_DIST defaults.
- Sub-module march_step: combinational pos + dir*t using vec3_scaled and vec3_add. The engine instantiates it once.
- The SDF evaluator stays external, so fractal selection is outside this block.

Test Plan:
- Origin (0,0,-5), dir (0,0,1), SDF model returns 0.005 on first query with L=3 -> valid_out 5 cycles after accept; hit_out=1, depth_out=0, color_out=15, dist_out=0.
- SDF returns 1.0, 1.0, 1.0, 0.0 -> three queries at z=-5,-4,-3, then hit at z=-2; depth_out=3, dist_out=3.0, color_out=15 (depth>>2 = 0).
- SDF constantly 0.5, MAX_DIST 16 -> far-plane miss after 32 steps, 33rd query terminates; hit_out=0, color_out=0, dist_out=16.0.
- SDF constantly 0.1, MAX_DIST large -> depth-limit miss: exactly 64 sdf_req_out pulses, depth_out=64, hit_out=0.
- Hold ready_in=0 for 10 cycles in RE_Done -> all outputs stable, ready_out=0, new valid_in ignored. ready_in=1 -> ready_out=1 next cycle.
- Assert rst_in during RE_Wait, then sdf_valid_in arrives -> state RE_Ready, no valid_out. Spurious sdf_valid_in while in RE_Ready is ignored.
